mixcol_share_arb: RTL and testbench

- Shares one combinational MixColumns datapath between two requesters: requester 0 is the encryption round engine, requester 1 is the self-test/key-check path.
- Round-robin arbitration, with a single-entry result buffer and ready/valid handshakes on both sides.
- Supports a per-request bypass so the final AES round (no MixColumns) uses the same path.
- Sits between the round controllers and the MixColumns function inside the AES core.

---
 rtl/mixcol_share_arb_if.sv | 35 +++
 rtl/mixcol_share_arb.sv | 95 +++++++++
 tb/tb_mixcol_share_arb.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mixcol_share_arb_if.sv
// Handshake bundle between two round requesters, the shared MixColumns arbiter and its consumer.
interface mixcol_share_arb_if #(
  parameter int CNT_W = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [127:0]     req0_data;
  logic             req0_bypass;
  logic             req1_valid;
  logic             req1_ready;
  logic [127:0]     req1_data;
  logic             req1_bypass;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [127:0]     rsp_data;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output req0_valid, req0_data, req0_bypass,
    output req1_valid, req1_data, req1_bypass,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, cnt0, cnt1
  );

  modport slave (
    input  req0_valid, req0_data, req0_bypass,
    input  req1_valid, req1_data, req1_bypass,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, cnt0, cnt1
  );
endinterface

// File: rtl/mixcol_share_arb.sv
// Round-robin share of one combinational MixColumns between two requesters.
// Single-entry result buffer; a new request may load on the same edge the old result drains.
module mixcol_share_arb #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  mixcol_share_arb_if.slave bus
);
  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t           r_state;
  logic [127:0]     r_held;
  logic             r_byp;
  logic             r_id;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic             w_take;
  logic             w_can;
  logic             w_gnt0;
  logic             w_gnt1;
  logic [127:0]     w_mix;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  assign w_take = (r_state == S_FULL) & bus.rsp_ready;
  // Ready is held low during reset even though the registers are already cleared.
  assign w_can  = !rst & ((r_state == S_EMPTY) | w_take);

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_can) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_gnt0 = r_last;
        w_gnt1 = !r_last;
      end else begin
        w_gnt0 = bus.req0_valid;
        w_gnt1 = bus.req1_valid;
      end
    end
  end

  always_comb begin
    w_mix = {mix_col(r_held[127:96]), mix_col(r_held[95:64]),
             mix_col(r_held[63:32]),  mix_col(r_held[31:0])};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_held  <= '0;
      r_byp   <= 1'b0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      if (w_take) begin
        if (r_id) r_cnt1 <= r_cnt1 + CNT_W'(1);
        else      r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
      if (w_gnt0 || w_gnt1) begin
        r_held  <= w_gnt1 ? bus.req1_data : bus.req0_data;
        r_byp   <= w_gnt1 ? bus.req1_bypass : bus.req0_bypass;
        r_id    <= w_gnt1;
        r_last  <= w_gnt1;
        r_state <= S_FULL;
      end else if (w_take) begin
        r_state <= S_EMPTY;
      end
    end
  end

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.rsp_valid  = (r_state == S_FULL);
  assign bus.rsp_id     = r_id;
  assign bus.rsp_data   = r_byp ? r_held : w_mix;
  assign bus.cnt0       = r_cnt0;
  assign bus.cnt1       = r_cnt1;
endmodule

// File: tb/tb_mixcol_share_arb.sv
// Directed and random stimulus for mixcol_share_arb against a queue-based reference with a
// matrix-multiply MixColumns model.
module tb_mixcol_share_arb;
  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mixcol_share_arb_if #(.CNT_W(CNT_W)) bus ();

  mixcol_share_arb #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         id;
    logic [127:0] data;
  } rsp_t;

  rsp_t         exp_q[$];
  logic         m_last;
  int           m_cnt0;
  int           m_cnt1;
  int           m_g;
  int           dut_g;
  logic [127:0] held_snap;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input int k);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic byp);
    int           m[4][4];
    logic [127:0] o;
    logic [7:0]   acc;
    m = '{'{2, 3, 1, 1}, '{1, 2, 3, 1}, '{1, 1, 2, 3}, '{3, 1, 1, 2}};
    if (byp) return s;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(s[127 - 32*c - 8*j -: 8], m[r][j]);
        o[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic tick();
    logic take;
    logic can;
    rsp_t e;
    @(negedge clk);
    take = (exp_q.size() != 0) && bus.rsp_ready;
    can  = (exp_q.size() == 0) || take;
    m_g  = -1;
    if (can) begin
      if (bus.req0_valid && bus.req1_valid) m_g = m_last ? 0 : 1;
      else if (bus.req0_valid)              m_g = 0;
      else if (bus.req1_valid)              m_g = 1;
    end
    dut_g = bus.req1_ready ? 1 : (bus.req0_ready ? 0 : -1);
    check("req0_ready", 128'(bus.req0_ready), 128'(m_g == 0));
    check("req1_ready", 128'(bus.req1_ready), 128'(m_g == 1));
    check("rsp_valid", 128'(bus.rsp_valid), 128'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check("rsp_id", 128'(bus.rsp_id), 128'(exp_q[0].id));
      check("rsp_data", bus.rsp_data, exp_q[0].data);
    end
    check("cnt0", 128'(bus.cnt0), 128'(m_cnt0));
    check("cnt1", 128'(bus.cnt1), 128'(m_cnt1));
    @(posedge clk);
    if (take) begin
      if (exp_q[0].id) m_cnt1 = (m_cnt1 + 1) % (1 << CNT_W);
      else             m_cnt0 = (m_cnt0 + 1) % (1 << CNT_W);
      void'(exp_q.pop_front());
    end
    if (m_g == 0) begin
      e.id = 1'b0;
      e.data = ref_mix(bus.req0_data, bus.req0_bypass);
      exp_q.push_back(e);
      m_last = 1'b0;
    end else if (m_g == 1) begin
      e.id = 1'b1;
      e.data = ref_mix(bus.req1_data, bus.req1_bypass);
      exp_q.push_back(e);
      m_last = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    check("rst_cnt0", 128'(bus.cnt0), 128'(0));
    check("rst_cnt1", 128'(bus.cnt1), 128'(0));
    check("rst_ready", 128'({bus.req0_ready, bus.req1_ready}), 128'(0));
    exp_q.delete();
    m_last = 1'b1;
    m_cnt0 = 0;
    m_cnt1 = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_data = '0;
    bus.req0_bypass = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_data = '0;
    bus.req1_bypass = 1'b0;
    bus.rsp_ready = 1'b1;
    do_reset();

    // First transaction from requester 0 only.
    bus.req1_valid = 1'b0;
    bus.req0_data = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    tick();
    bus.req0_valid = 1'b0;
    check("vec0_data", bus.rsp_data, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    check("vec0_id", 128'(bus.rsp_id), 128'(0));
    tick();
    check("vec0_cnt0", 128'(bus.cnt0), 128'(1));

    // Requester 1 only.
    bus.req1_valid = 1'b1;
    bus.req1_data = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    tick();
    bus.req1_valid = 1'b0;
    check("vec1_data", bus.rsp_data, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff);
    check("vec1_id", 128'(bus.rsp_id), 128'(1));
    tick();

    // Bypass path.
    bus.req0_valid = 1'b1;
    bus.req0_bypass = 1'b1;
    bus.req0_data = 128'h0123456789abcdeffedcba9876543210;
    tick();
    bus.req0_valid = 1'b0;
    bus.req0_bypass = 1'b0;
    check("bypass_data", bus.rsp_data, 128'h0123456789abcdeffedcba9876543210);
    tick();

    // Continuous contention after reset alternates starting with requester 0.
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.req0_data = rnd128();
      bus.req1_data = rnd128();
      tick();
      check("alt_grant", 128'(dut_g), 128'(i % 2));
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    check("alt_cnt0", 128'(bus.cnt0), 128'(3));
    check("alt_cnt1", 128'(bus.cnt1), 128'(3));

    // Backpressure with both requesters waiting, then release with no gap.
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    held_snap = bus.rsp_data;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_stable", bus.rsp_data, held_snap);
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("bp_nogap_valid", 128'(bus.rsp_valid), 128'(1));
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();

    // Reset while holding a result under backpressure.
    bus.req1_valid = 1'b1;
    tick();
    bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    tick();
    check("pre_rst_full", 128'(bus.rsp_valid), 128'(1));
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    tick();
    check("post_rst_grant", 128'(dut_g), 128'(0));
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();

    // Counter wrap: 17 responses from requester 0.
    do_reset();
    bus.req0_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.req0_data = rnd128();
      tick();
    end
    bus.req0_valid = 1'b0;
    tick();
    check("wrap_cnt0", 128'(bus.cnt0), 128'(1));

    // Random traffic; a requester keeps its request stable until it is accepted.
    for (int i = 0; i < 300; i++) begin
      if (!bus.req0_valid || m_g == 0) begin
        bus.req0_valid = ($urandom_range(3) != 0);
        bus.req0_data = rnd128();
        bus.req0_bypass = ($urandom_range(3) == 0);
      end
      if (!bus.req1_valid || m_g == 1) begin
        bus.req1_valid = ($urandom_range(3) != 0);
        bus.req1_data = rnd128();
        bus.req1_bypass = ($urandom_range(3) == 0);
      end
      bus.rsp_ready = ($urandom_range(3) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
